// File: rtl/rr_encoder_arbiter_pkg.sv
// Shared definitions for the round-robin encoder arbiter.
//   NREQ    : number of requesters sharing the resource
//   IDW     : width of the binary requester index
//   state_t : arbiter state encoding (ST_IDLE / ST_BUSY)
package rr_encoder_arbiter_pkg;

  localparam int NREQ = 8;
  localparam int IDW  = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1
  } state_t;

  // Index of the requester after id, wrapping 7 -> 0.
  function automatic logic [IDW-1:0] next_id(input logic [IDW-1:0] id);
    return id + IDW'(1);
  endfunction

endpackage

// File: rtl/rr_encoder_arbiter_pick8.sv
// rr_pick8: combinational round-robin winner selection.
// Ports:
//   req        in  [7:0] request vector
//   ptr        in  [2:0] highest-priority requester this round
//   any        out       at least one request present
//   win_id     out [2:0] index of the first set request at or after ptr (wrapping)
//   win_onehot out [7:0] one-hot of win_id, zero when no request
module rr_pick8
  import rr_encoder_arbiter_pkg::*;
(
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic            any,
  output logic [IDW-1:0]  win_id,
  output logic [NREQ-1:0] win_onehot
);

  logic [2*NREQ-1:0] req_dbl;
  logic [NREQ-1:0]   req_rot;
  logic [IDW-1:0]    rot_id;

  // Rotate so that requester ptr lands on bit 0: req_rot[j] = req[(ptr+j) mod 8].
  assign req_dbl = {req, req};
  assign req_rot = req_dbl[ptr +: NREQ];

  // Priority encode, lowest index wins (scan from the top so the lowest overwrites).
  always_comb begin
    rot_id = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_rot[i]) rot_id = IDW'(i);
    end
  end

  assign any        = |req;
  assign win_id     = rot_id + ptr;  // un-rotate; 3-bit add wraps mod 8
  assign win_onehot = any ? (NREQ'(1) << win_id) : '0;

endmodule

// File: rtl/rr_encoder_arbiter.sv
// rr_encoder_arbiter: round-robin arbiter granting one of 8 requesters a shared
// resource, holding the grant until release, with an optional hold timeout.
// Parameters:
//   MAX_HOLD : max cycles per tenure while others wait (0 = no timeout)
//   CNT_W    : hold counter width, MAX_HOLD <= 2**CNT_W-1
// Ports:
//   clk         in       rising-edge clock
//   rst_n       in       asynchronous active-low reset
//   en          in       enable; low blocks new grants and revokes the current one
//   req         in [7:0] request vector
//   done        in       release pulse from the current grantee
//   grant       out[7:0] registered one-hot grant, zero when idle
//   grant_id    out[2:0] registered index of the grantee, zero when idle
//   grant_valid out      registered, high while a grant is held
module rr_encoder_arbiter
  import rr_encoder_arbiter_pkg::*;
#(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic [NREQ-1:0] req,
  input  logic            done,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  grant_id,
  output logic            grant_valid
);

  localparam int LIMIT = (MAX_HOLD > 0) ? MAX_HOLD - 1 : 0;

  state_t          state;
  logic [IDW-1:0]  ptr;
  logic [CNT_W-1:0] hold_cnt;

  logic            any;
  logic [IDW-1:0]  win_id;
  logic [NREQ-1:0] win_onehot;
  logic            timeout;
  logic            release_now;

  rr_pick8 u_pick (
    .req        (req),
    .ptr        (ptr),
    .any        (any),
    .win_id     (win_id),
    .win_onehot (win_onehot)
  );

  // Timeout only forces a release when someone else is actually waiting.
  assign timeout     = (MAX_HOLD != 0) && (32'(hold_cnt) >= 32'(LIMIT)) && (|(req & ~grant));
  assign release_now = done || !req[grant_id] || !en || timeout;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      ptr         <= '0;
      hold_cnt    <= '0;
      grant       <= '0;
      grant_id    <= '0;
      grant_valid <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (en && any) begin
            state       <= ST_BUSY;
            grant       <= win_onehot;
            grant_id    <= win_id;
            grant_valid <= 1'b1;
            hold_cnt    <= '0;
          end
        end
        ST_BUSY: begin
          if (release_now) begin
            state       <= ST_IDLE;
            ptr         <= next_id(grant_id);
            grant       <= '0;
            grant_id    <= '0;
            grant_valid <= 1'b0;
          end else if (hold_cnt != '1) begin
            hold_cnt <= hold_cnt + CNT_W'(1);
          end
        end
        default: begin
          state       <= ST_IDLE;
          grant       <= '0;
          grant_id    <= '0;
          grant_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
